wash_sequencer: RTL and testbench
=================================

# wash_sequencer

Central sequencing FSM of the washing-machine controller: the issuing side of the duration-code / trigger interface to the minute timer. It walks the wash programme IDLE → FILL → WASH → RINSE → (optional second WASH/RINSE) → SPIN → DONE. In each phase it drives the phase duration code to the timer and advances on the timer's trigger. It also gates the user pause request so that pausing takes effect only during SPIN.

## Interface
Parameters:
- ARM_CYCLES, 2, cycles after each phase entry during which Trigger_clk_timer is ignored (timer restart latency); legal range 1–15.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_n  in  1  synchronous, active-low reset. Reset is sampled on the CLK rising edge; there is no asynchronous path.
- Coin_in  in  1  start request; level-sampled, honoured only in IDLE.
- Double_wash  in  1  programme option; sampled on the same edge as an accepted Coin_in.
- Pause_req  in  1  user pause request, level.
- Trigger_clk_timer  in  1  timer expiry flag, level; the timer clears it on a duration-code change.
- Duration_clk_timer  out  3  phase code to the timer: A=000 idle, B=001 fill, C=010 wash, D=011 rinse, E=100 spin, F=101 done.
- Timer_pause  out  1  pause to the timer.
- Wash_done  out  1  one-cycle completion pulse.
- Busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FILL, WASH, RINSE, SPIN, DONE. Duration_clk_timer equals the state's code (A, B, C, D, E, F respectively) as a registered Moore output.
- Qualified trigger (qtrig): Trigger_clk_timer==1 AND arm_cnt==ARM_CYCLES.
  - arm_cnt is 4 bits. It is cleared on the edge that enters any state, increments each cycle, and saturates at ARM_CYCLES.
- Transitions:
  - IDLE: Coin_in=1 → FILL. On the same edge, latch dbl ← Double_wash and clear pass ← 0.
  - FILL: qtrig → WASH.
  - WASH: qtrig → RINSE.
  - RINSE: on qtrig:
    - if dbl=1 and pass=0 → WASH, and set pass ← 1;
    - otherwise → SPIN.
  - SPIN: qtrig → DONE. No transition while Timer_pause=1, even if qtrig=1.
  - DONE: → IDLE unconditionally after one cycle.
- Timer_pause is registered: next value = Pause_req AND (next state == SPIN). Pause_req in any other state has no effect.
- Wash_done is registered and equals 1 exactly for the cycle the FSM is in DONE.
- Busy = (state != IDLE).
- Coin_in outside IDLE is ignored. Changes to Double_wash after acceptance are ignored.
- Trigger_clk_timer held high from the previous phase is never counted, because of the arm window.

## Timing
- Reset values, one edge after RST_n=0:
  - outputs: Duration_clk_timer=000, Timer_pause=0, Wash_done=0, Busy=0;
  - internal: state=IDLE, arm_cnt=0, dbl=0, pass=0.
- RST_n=0 mid-programme (e.g. in WASH) returns to IDLE on that edge and discards dbl/pass. The first Coin_in accepted after reset release starts a fresh programme.
- Coin_in high at edge N → Duration=B visible after edge N.
- Phase entry at edge N: a trigger is first counted at edge N+ARM_CYCLES+1, and the new code is visible after that edge.
- Trigger and Pause_req rising in the same SPIN cycle: the pause wins. The FSM stays in SPIN and Timer_pause=1 from the next edge.
- Reset and Coin_in on the same edge: reset wins.
- Phase count: single programme = 4 timed phases; double programme = 6 (B, C, D, C, D, E).

## Structure
- Shared package wash_pkg, also used by the timer, holds:
  - the 3-bit phase codes A–F;
  - the 2-bit CLK_freq codes (MHz1=00, MHz2=01, MHz4=10, MHz8=11);
  - a typedef'd phase enumeration.
- The arm counter plus qtrig logic forms one natural sub-module, trigger_qualifier. Its ports: CLK, RST_n, restart, Trigger_clk_timer, qtrig; parameter ARM_CYCLES.
- Everything else (FSM, dbl/pass flags, output registers) lives in wash_sequencer.

## Test plan
- Reset: hold RST_n=0 for 3 edges with Coin_in=1 → Duration=000, Busy=0, Wash_done=0 throughout. Release, hold Coin_in=1 one cycle → Duration=001 after the next edge.
- Single programme, trigger driven high 5 cycles after each phase entry → code sequence 001, 010, 011, 100, 101, 000. Wash_done=1 for exactly one cycle.
- Double_wash=1 at Coin_in, then Double_wash=0 → code sequence 001, 010, 011, 010, 011, 100, 101, 000.
- Stale trigger: Trigger_clk_timer held at 1 continuously, ARM_CYCLES=2 → each phase lasts exactly 3 cycles. Trigger is never counted at arm_cnt<2.
- Pause: Pause_req=1 in WASH → Timer_pause stays 0. Pause_req=1 in SPIN with trigger=1 → Timer_pause=1 and state held in SPIN. Drop pause → DONE after re-qualification.
- Reset mid-RINSE in a double programme, then new Coin_in with Double_wash=0 → single sequence, with no leftover pass/dbl effect.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared definitions for the washer controller: phase codes driven to the
// minute timer, timer clock-frequency codes, and the phase enumeration.
package wash_pkg;

    // Duration codes on the sequencer -> timer interface
    localparam logic [2:0] CODE_A = 3'b000;  // idle
    localparam logic [2:0] CODE_B = 3'b001;  // fill
    localparam logic [2:0] CODE_C = 3'b010;  // wash
    localparam logic [2:0] CODE_D = 3'b011;  // rinse
    localparam logic [2:0] CODE_E = 3'b100;  // spin
    localparam logic [2:0] CODE_F = 3'b101;  // done

    // Timer input-clock selection codes
    typedef enum logic [1:0] {
        MHZ1 = 2'b00,
        MHZ2 = 2'b01,
        MHZ4 = 2'b10,
        MHZ8 = 2'b11
    } clk_freq_e;

    // Phase encoding equals the duration code, so the state register can
    // drive the timer directly with no decode.
    typedef enum logic [2:0] {
        PH_IDLE  = CODE_A,
        PH_FILL  = CODE_B,
        PH_WASH  = CODE_C,
        PH_RINSE = CODE_D,
        PH_SPIN  = CODE_E,
        PH_DONE  = CODE_F
    } phase_e;

    function automatic logic [2:0] phase_code(input phase_e p);
        return 3'(p);
    endfunction

endpackage

// File: rtl/wash_sequencer_trigger_qualifier.sv
// Arm-window counter: masks the timer trigger for ARM_CYCLES cycles after
// each phase entry so a trigger left high from the previous phase is not
// counted before the timer has restarted.
module trigger_qualifier #(
    parameter int unsigned ARM_CYCLES = 2
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic restart,
    input  logic Trigger_clk_timer,
    output logic qtrig
);

    localparam logic [3:0] ARM_MAX = 4'(ARM_CYCLES);

    logic [3:0] arm_cnt_q, arm_cnt_d;

    // Clear on phase entry, otherwise count up and saturate at ARM_MAX
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        if (restart)
            arm_cnt_d = '0;
        else if (arm_cnt_q < ARM_MAX)
            arm_cnt_d = arm_cnt_q + 4'd1;
    end

    // Arm counter register
    always_ff @(posedge CLK) begin
        if (!RST_n)
            arm_cnt_q <= '0;
        else
            arm_cnt_q <= arm_cnt_d;
    end

    assign qtrig = Trigger_clk_timer && (arm_cnt_q == ARM_MAX);

endmodule

// File: rtl/wash_sequencer.sv
// Wash programme sequencer: steps FILL/WASH/RINSE(/WASH/RINSE)/SPIN/DONE,
// presents the phase code to the minute timer and advances on the
// qualified timer trigger. User pause is only forwarded during SPIN.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int unsigned ARM_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       Coin_in,
    input  logic       Double_wash,
    input  logic       Pause_req,
    input  logic       Trigger_clk_timer,
    output logic [2:0] Duration_clk_timer,
    output logic       Timer_pause,
    output logic       Wash_done,
    output logic       Busy
);

    phase_e state_q, state_d;
    logic   dbl_q, dbl_d;      // double programme selected at coin time
    logic   pass_q, pass_d;    // second wash/rinse pass already taken
    logic   pause_q, pause_d;
    logic   done_q, done_d;
    logic   qtrig;
    logic   restart;

    // Any state change re-arms the trigger window
    assign restart = (state_d != state_q);

    trigger_qualifier #(
        .ARM_CYCLES (ARM_CYCLES)
    ) u_tq (
        .CLK               (CLK),
        .RST_n             (RST_n),
        .restart           (restart),
        .Trigger_clk_timer (Trigger_clk_timer),
        .qtrig             (qtrig)
    );

    // Next-state, programme flags and next output values
    always_comb begin
        state_d = state_q;
        dbl_d   = dbl_q;
        pass_d  = pass_q;
        unique case (state_q)
            PH_IDLE: begin
                if (Coin_in) begin
                    state_d = PH_FILL;
                    dbl_d   = Double_wash;
                    pass_d  = 1'b0;
                end
            end
            PH_FILL:  if (qtrig) state_d = PH_WASH;
            PH_WASH:  if (qtrig) state_d = PH_RINSE;
            PH_RINSE: begin
                if (qtrig) begin
                    if (dbl_q && !pass_q) begin
                        state_d = PH_WASH;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = PH_SPIN;
                    end
                end
            end
            // A fresh pause request beats a coincident trigger, and the
            // held pause keeps SPIN frozen until it is released.
            PH_SPIN:  if (qtrig && !Pause_req && !pause_q) state_d = PH_DONE;
            PH_DONE:  state_d = PH_IDLE;
            default:  state_d = PH_IDLE;
        endcase
        pause_d = Pause_req && (state_d == PH_SPIN);
        done_d  = (state_d == PH_DONE);
    end

    // State, flags and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q <= PH_IDLE;
            dbl_q   <= 1'b0;
            pass_q  <= 1'b0;
            pause_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dbl_q   <= dbl_d;
            pass_q  <= pass_d;
            pause_q <= pause_d;
            done_q  <= done_d;
        end
    end

    assign Duration_clk_timer = phase_code(state_q);
    assign Timer_pause        = pause_q;
    assign Wash_done          = done_q;
    assign Busy               = (state_q != PH_IDLE);

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: a per-edge vector table for reset,
// stale-trigger single/double programmes and pause-outside-SPIN, plus
// hand sequences for delayed triggers, SPIN pause and mid-programme reset.
module tb_wash_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, coin, dblw, pause, trig;
    logic [2:0] dur;
    logic       tpause, done, busy;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic       rst_n, coin, dbl, pause, trig;
        logic [2:0] dur;
        logic       tp, done, busy;
    } vec_t;

    vec_t       tbl[$];
    logic [2:0] exp_q[$];

    wash_sequencer #(.ARM_CYCLES(2)) dut (
        .CLK                (clk),
        .RST_n              (rst_n),
        .Coin_in            (coin),
        .Double_wash        (dblw),
        .Pause_req          (pause),
        .Trigger_clk_timer  (trig),
        .Duration_clk_timer (dur),
        .Timer_pause        (tpause),
        .Wash_done          (done),
        .Busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic addn(input int n, input logic r, input logic c, input logic d,
                        input logic p, input logic t, input logic [2:0] du,
                        input logic tp, input logic dn, input logic b);
        vec_t v;
        v.rst_n = r; v.coin = c; v.dbl = d; v.pause = p; v.trig = t;
        v.dur = du; v.tp = tp; v.done = dn; v.busy = b;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Start a programme, keep the trigger low for dly edges after each
    // phase entry then raise it until the code changes; collect codes.
    task automatic run_prog(input logic d, input int dly, input string nm);
        logic [2:0] seen[$];
        logic [2:0] last;
        int cnt, dones, cyc;
        @(negedge clk);
        coin = 1'b1; dblw = d; trig = 1'b0; pause = 1'b0;
        step();
        last = dur; seen.push_back(dur);
        cnt = 0; dones = 0; cyc = 0;
        @(negedge clk);
        coin = 1'b0; dblw = ~d;
        while (last != 3'b000 && cyc < 300) begin
            @(negedge clk);
            trig = (cnt >= dly);
            step();
            cyc++; cnt++;
            if (done) dones++;
            if (dur != last) begin
                last = dur; seen.push_back(dur); cnt = 0;
            end
        end
        trig = 1'b0;
        chk({nm, " finished"}, 32'(cyc < 300), 32'd1);
        chk({nm, " length"}, 32'(seen.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seen.size(); i++)
            chk({nm, $sformatf(" code[%0d]", i)}, 32'(seen[i]), 32'(exp_q[i]));
        chk({nm, " done pulses"}, 32'(dones), 32'd1);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; coin = 1'b0; dblw = 1'b0; pause = 1'b0; trig = 1'b0;

        // Reset with coin held: reset wins
        addn(3, 0, 1, 0, 0, 1, 3'b000, 0, 0, 0);
        // Single programme, trigger stuck high: 3 cycles per phase
        addn(1, 1, 1, 0, 0, 1, 3'b001, 0, 0, 1);
        addn(1, 1, 1, 0, 0, 1, 3'b001, 0, 0, 1);   // coin ignored in FILL
        addn(1, 1, 0, 0, 0, 1, 3'b001, 0, 0, 1);
        addn(3, 1, 0, 0, 0, 1, 3'b010, 0, 0, 1);
        addn(3, 1, 0, 0, 0, 1, 3'b011, 0, 0, 1);
        addn(3, 1, 0, 0, 0, 1, 3'b100, 0, 0, 1);
        addn(1, 1, 0, 0, 0, 1, 3'b101, 0, 1, 1);
        addn(2, 1, 0, 0, 0, 1, 3'b000, 0, 0, 0);
        // Double programme, option dropped after acceptance; pause in WASH
        addn(1, 1, 1, 1, 0, 1, 3'b001, 0, 0, 1);
        addn(2, 1, 0, 0, 0, 1, 3'b001, 0, 0, 1);
        addn(3, 1, 0, 0, 1, 1, 3'b010, 0, 0, 1);
        addn(3, 1, 0, 0, 0, 1, 3'b011, 0, 0, 1);
        addn(3, 1, 0, 0, 1, 1, 3'b010, 0, 0, 1);
        addn(3, 1, 0, 0, 0, 1, 3'b011, 0, 0, 1);
        addn(3, 1, 0, 0, 0, 1, 3'b100, 0, 0, 1);
        addn(1, 1, 0, 0, 0, 1, 3'b101, 0, 1, 1);
        addn(1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n; coin = tbl[i].coin; dblw = tbl[i].dbl;
            pause = tbl[i].pause; trig = tbl[i].trig;
            step();
            chk($sformatf("vec%0d dur", i),   32'(dur),    32'(tbl[i].dur));
            chk($sformatf("vec%0d tpause", i), 32'(tpause), 32'(tbl[i].tp));
            chk($sformatf("vec%0d done", i),  32'(done),   32'(tbl[i].done));
            chk($sformatf("vec%0d busy", i),  32'(busy),   32'(tbl[i].busy));
        end

        // Delayed trigger (5 cycles after entry), single and double
        exp_q = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000};
        run_prog(1'b0, 5, "single");
        exp_q = '{3'b001, 3'b010, 3'b011, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000};
        run_prog(1'b1, 5, "double");

        // Pause in SPIN coinciding with a trigger
        @(negedge clk);
        coin = 1'b1; dblw = 1'b0; trig = 1'b1;
        step();
        @(negedge clk); coin = 1'b0;
        guard = 0;
        while (dur != 3'b100 && guard < 50) begin step(); guard++; end
        chk("reach spin", 32'(dur), 32'h4);
        @(negedge clk); trig = 1'b0;
        repeat (3) step();
        @(negedge clk); trig = 1'b1; pause = 1'b1;
        step();
        chk("spin pause wins dur", 32'(dur), 32'h4);
        chk("spin pause tp", 32'(tpause), 32'd1);
        repeat (2) step();
        chk("spin held dur", 32'(dur), 32'h4);
        chk("spin held tp", 32'(tpause), 32'd1);
        @(negedge clk); pause = 1'b0;
        step();
        chk("unpause dur", 32'(dur), 32'h4);
        chk("unpause tp", 32'(tpause), 32'd0);
        step();
        chk("after pause dur", 32'(dur), 32'h5);
        chk("after pause done", 32'(done), 32'd1);
        @(negedge clk); trig = 1'b0;
        step();
        chk("after pause idle", 32'(dur), 32'h0);

        // Reset mid-RINSE of a double programme, then a fresh single one
        @(negedge clk);
        coin = 1'b1; dblw = 1'b1; trig = 1'b1;
        step();
        @(negedge clk); coin = 1'b0;
        guard = 0;
        while (dur != 3'b011 && guard < 50) begin step(); guard++; end
        chk("reach rinse", 32'(dur), 32'h3);
        @(negedge clk); rst_n = 1'b0; dblw = 1'b0; trig = 1'b0;
        step();
        chk("mid reset dur", 32'(dur), 32'h0);
        chk("mid reset busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        exp_q = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000};
        run_prog(1'b0, 5, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
